// File: rtl/sram_responder.sv
// Single-port word-organised SRAM behind a valid/ready request/response pair.
// Each request is answered exactly LATENCY cycles after it is accepted.
module sram_responder #(
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wen_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic        zero_q;

    logic                  accept;
    logic                  commit;
    logic [29:0]           word_off;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  out_of_range;
    logic                  misaligned;
    logic                  acc_err;
    logic [3:0]            size_strb;
    logic [3:0]            strb;
    logic [31:0]           wdata_sh;
    logic                  mem_we;
    logic [31:0]           rd_word;

    assign accept = (state_q == ST_IDLE) && req_valid;
    assign commit = (state_q == ST_WAIT) && (cnt_q == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wen_q   <= req_wen;
            addr_q  <= req_addr;
            size_q  <= req_size;
            wdata_q <= req_wdata;
        end
    end

    // Offset wraps modulo 2^32, so addresses below BASE land far out of range.
    assign word_off     = 30'((addr_q - BASE) >> 2);
    assign word_idx     = word_off[DEPTH_LOG2-1:0];
    assign out_of_range = |word_off[29:DEPTH_LOG2];

    always_comb begin
        size_strb  = 4'b0000;
        misaligned = 1'b0;
        case (size_q)
            2'b00: size_strb = 4'b0001;
            2'b01: begin
                size_strb  = 4'b0011;
                misaligned = addr_q[0];
            end
            2'b10: begin
                size_strb  = 4'b1111;
                misaligned = (addr_q[1:0] != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

    assign acc_err  = out_of_range || misaligned;
    assign strb     = size_strb << addr_q[1:0];
    assign wdata_sh = wdata_q << {addr_q[1:0], 3'b000};
    assign mem_we   = commit && wen_q && !acc_err && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q  <= 1'b0;
            zero_q <= 1'b1;
        end else if (commit) begin
            err_q  <= acc_err;
            zero_q <= wen_q || acc_err;
        end
    end

    // One byte-wide RAM per lane keeps strobed writes simple to infer.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_q;

            always_ff @(posedge clk) begin
                if (mem_we && strb[gi]) mem[word_idx] <= wdata_sh[8*gi +: 8];
                if (commit)             rd_q          <= mem[word_idx];
            end

            assign rd_word[8*gi +: 8] = rd_q;
        end
    endgenerate

    assign resp_rdata = zero_q ? 32'd0 : rd_word;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: randomized accesses checked against a
// byte-addressed reference memory, plus directed stall and reset-abort cases.
module tb_sram_responder;

    parameter int LAT = 2;
    localparam int          DLOG = 10;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    sram_responder #(.BASE(BASE), .DEPTH_LOG2(DLOG), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model [logic [31:0]];
    int         checks = 0;
    int         errors = 0;
    bit         force_hold = 0;
    int         last_consume = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_err(input logic [31:0] a, input logic [1:0] sz);
        longint unsigned off;
        int nbytes;
        off = longint'(a - BASE);
        if (off >= (64'd4 << DLOG)) return 1'b1;
        if (sz == 2'b11) return 1'b1;
        nbytes = 1 << sz;
        return (a % nbytes) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'd3;
        return {model[w + 3], model[w + 2], model[w + 1], model[w]};
    endfunction

    // Present one request, wait (bounded) for acceptance, then record the expectation.
    task automatic do_req(input bit wen, input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] wd, input bit abort, output int acc);
        int   n;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = a;
        req_size  = sz;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready stuck at 0 for addr 0x%08h", a);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc       = cyc;
        req_valid = 1'b0;
        req_wen   = 1'($urandom);
        req_addr  = $urandom;
        req_size  = 2'($urandom);
        req_wdata = $urandom;
        if (!abort) begin
            e.addr  = a;
            e.acc   = acc;
            e.err   = model_err(a, sz);
            e.rdata = (wen || e.err) ? 32'd0 : model_load(a);
            if (wen && !e.err)
                for (int k = 0; k < (1 << sz); k++) model[a + k] = wd[8*k +: 8];
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || resp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || resp_valid) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding", sb.size());
        end
    endtask

    // Response consumer: stalls a random (or forced 5-cycle) number of cycles.
    initial begin
        int wait_cnt;
        int hold_target;
        wait_cnt    = 0;
        hold_target = 0;
        resp_ready  = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                resp_ready = (wait_cnt >= hold_target);
                wait_cnt++;
            end else begin
                resp_ready  = 1'b0;
                wait_cnt    = 0;
                hold_target = force_hold ? 5 : $urandom_range(0, 3);
            end
        end
    end

    initial begin
        bit   prev_valid;
        bit   have_cur;
        exp_t cur;
        prev_valid = 1'b0;
        have_cur   = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_valid = 1'b0;
                have_cur   = 1'b0;
            end else begin
                if (resp_valid && !prev_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        have_cur = 1'b0;
                        $display("FAIL unexpected_resp: rdata 0x%08h err %0b with nothing pending", resp_rdata, resp_err);
                    end else begin
                        cur      = sb.pop_front();
                        have_cur = 1'b1;
                        check("latency", 32'(cyc - cur.acc), 32'(LAT));
                        $display("txn addr=0x%08h rdata=0x%08h err=%0b exp_rdata=0x%08h exp_err=%0b",
                                 cur.addr, resp_rdata, resp_err, cur.rdata, cur.err);
                    end
                end
                if (resp_valid && have_cur) begin
                    check("rdata", resp_rdata, cur.rdata);
                    check("err", {31'd0, resp_err}, {31'd0, cur.err});
                    check("ready_in_resp", {31'd0, req_ready}, 32'd0);
                end
                if (resp_valid && resp_ready) last_consume = cyc + 1;
                prev_valid = resp_valid;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        int          acc_b;
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = 32'd0;
        req_size  = 2'd0;
        req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);

        for (int i = 0; i < 16; i++) do_req(1'b1, BASE + 32'(4 * i), 2'b10, $urandom, 1'b0, acc);

        do_req(1'b1, BASE + 32'h10, 2'b10, 32'hDEAD_BEEF, 1'b0, acc);
        do_req(1'b0, BASE + 32'h10, 2'b10, 32'd0, 1'b0, acc);

        do_req(1'b1, BASE + 32'h10, 2'b10, 32'h1122_3344, 1'b0, acc);
        do_req(1'b1, BASE + 32'h13, 2'b00, 32'h0000_00AA, 1'b0, acc);
        do_req(1'b0, BASE + 32'h10, 2'b10, 32'd0, 1'b0, acc);

        do_req(1'b1, BASE + 32'h01, 2'b01, 32'h0000_5A5A, 1'b0, acc);
        do_req(1'b0, BASE + 32'h00, 2'b10, 32'd0, 1'b0, acc);
        do_req(1'b0, BASE + (32'd4 << DLOG), 2'b10, 32'd0, 1'b0, acc);
        drain();

        force_hold = 1'b1;
        do_req(1'b0, BASE + 32'h10, 2'b10, 32'd0, 1'b0, acc);
        do_req(1'b1, BASE + 32'h30, 2'b10, 32'hCAFE_F00D, 1'b0, acc_b);
        force_hold = 1'b0;
        check("accept_after_consume", 32'(acc_b), 32'(last_consume + 1));
        drain();

        do_req(1'b1, BASE + 32'h20, 2'b10, 32'd0, 1'b0, acc);
        do_req(1'b0, BASE + 32'h10, 2'b10, 32'd0, 1'b0, acc);
        drain();
        do_req(1'b1, BASE + 32'h20, 2'b10, 32'h1234_5678, 1'b1, acc);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("abort_rdata", resp_rdata, 32'd0);
        check("abort_err", {31'd0, resp_err}, 32'd0);
        do_req(1'b0, BASE + 32'h20, 2'b10, 32'd0, 1'b0, acc);
        drain();

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = BASE + (32'd4 << DLOG) + 32'($urandom_range(0, 4095));
            else if (r == 1) a = BASE - 32'(4 * $urandom_range(1, 1000));
            else             a = BASE + 32'($urandom_range(0, 63));
            sz = 2'($urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), a, sz, $urandom, 1'b0, acc);
        end
        drain();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
